// File: rtl/alpha_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package alpha_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic [1:0] owner_onehot(input logic sel);
    owner_onehot = (sel == SEL_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux21.sv
// Two-input word multiplexer: sel=0 picks a, sel=1 picks b.
module mux21 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch requester (A)
// and a load/store requester (B); one transaction in flight at a time.
module mem_port_arbiter
  import alpha_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [1:0]       we,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  arb_state_t state;
  arb_state_t next_state;
  logic       owner;
  logic       next_owner;
  logic       last_owner;
  logic       capture;

  // Next-state and owner selection; on a tie the requester that did not go last wins.
  always_comb begin
    next_state = state;
    next_owner = owner;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          next_owner = ~last_owner;
          next_state = BUSY;
        end else if (req == 2'b01) begin
          next_owner = SEL_A;
          next_state = BUSY;
        end else if (req == 2'b10) begin
          next_owner = SEL_B;
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          next_state = BUSY;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, ownership, read-data capture and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= SEL_A;
      last_owner <= SEL_B;
      gnt        <= 2'b00;
      rdata      <= {WIDTH{1'b0}};
      mem_req    <= 1'b0;
    end else begin
      state   <= next_state;
      owner   <= next_owner;
      mem_req <= (next_state == BUSY);
      // gnt is set on the BUSY->DONE edge so it is high exactly for the DONE cycle
      if (capture) begin
        rdata      <= mem_rdata;
        last_owner <= owner;
        gnt        <= owner_onehot(owner);
      end else begin
        gnt        <= 2'b00;
      end
    end
  end

  mux21 #(.WIDTH(WIDTH)) u_addr_mux (
    .sel (owner),
    .a   (addr_a),
    .b   (addr_b),
    .y   (mem_addr)
  );

  mux21 #(.WIDTH(WIDTH)) u_wdata_mux (
    .sel (owner),
    .a   (wdata_a),
    .b   (wdata_b),
    .y   (mem_wdata)
  );

  assign mem_we = we[owner];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory transactions and grants,
// a monitor pops and compares them as the arbiter presents them.
module tb_mem_port_arbiter;

  localparam int W = 32;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           len;
  } txn_t;

  typedef struct {
    logic [1:0]   g;
    logic [W-1:0] d;
  } gnt_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] addr_a = '0, addr_b = '0, wdata_a = '0, wdata_b = '0;
  logic [1:0]   we = 2'b00;
  logic [1:0]   gnt;
  logic [W-1:0] rdata;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic         mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  int           ack_wait = 0;
  logic [W-1:0] resp_key = '0;
  logic         force_ack = 1'b0;

  txn_t exp_txn[$];
  gnt_t exp_gnt[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .wdata_a   (wdata_a),
    .wdata_b   (wdata_b),
    .we        (we),
    .gnt       (gnt),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_wait extra BUSY cycles; read data = addr ^ resp_key.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_addr ^ resp_key;
      if (mem_req) begin
        if (cnt == ack_wait) begin
          mem_ack = 1'b1;
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = force_ack;
        cnt = 0;
      end
    end
  end

  // Monitor: checks each memory transaction and each grant against the queues.
  initial begin
    logic prev_req;
    int   busy_len;
    txn_t cur;
    gnt_t eg;
    prev_req = 1'b0;
    busy_len = 0;
    cur.len  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !prev_req) begin
        busy_len = 0;
        if (exp_txn.size() == 0) begin
          check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
          cur.len = 0;
        end else begin
          cur = exp_txn.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
          check("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_req) busy_len++;
      if (!mem_req && prev_req && cur.len != 0)
        check("mem_req_len", busy_len, cur.len);
      prev_req = mem_req;
      if (gnt != 2'b00) begin
        if (exp_gnt.size() == 0) begin
          check("unexpected_gnt", {30'd0, gnt}, 32'd0);
        end else begin
          eg = exp_gnt.pop_front();
          check("gnt", {30'd0, gnt}, {30'd0, eg.g});
          check("rdata", rdata, eg.d);
        end
      end
    end
  end

  task automatic push_txn(input logic w, input logic [W-1:0] a, input logic [W-1:0] d, input int len);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d; t.len = len;
    exp_txn.push_back(t);
  endtask

  task automatic push_gnt(input logic [1:0] g, input logic [W-1:0] d);
    gnt_t e;
    e.g = g; e.d = d;
    exp_gnt.push_back(e);
  endtask

  task automatic wait_gnt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) return;
    end
    check("gnt_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b1;

    // Single read from A, one wait cycle
    @(negedge clk);
    addr_a = 32'hABCEDF12; wdata_a = 32'h0; we = 2'b00;
    resp_key = 32'hABCEDF12 ^ 32'h12345678; ack_wait = 1;
    push_txn(1'b0, 32'hABCEDF12, 32'h0, 2);
    push_gnt(2'b01, 32'h12345678);
    req = 2'b01;
    wait_gnt(20);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Continuous tie from reset: A,B,A,B
    do_reset();
    addr_a = 32'h00001000; addr_b = 32'h00002000; wdata_a = 32'h0; wdata_b = 32'h0;
    resp_key = 32'hFFFF0000; ack_wait = 0;
    for (int k = 0; k < 2; k++) begin
      push_txn(1'b0, 32'h00001000, 32'h0, 1);
      push_gnt(2'b01, 32'hFFFF1000);
      push_txn(1'b0, 32'h00002000, 32'h0, 1);
      push_gnt(2'b10, 32'hFFFF2000);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_gnt(20);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // B write with three wait cycles
    addr_b = 32'h00000100; wdata_b = 32'hDEADBEEF; we = 2'b10;
    resp_key = 32'h0; ack_wait = 3;
    push_txn(1'b1, 32'h00000100, 32'hDEADBEEF, 4);
    push_gnt(2'b10, 32'h00000100);
    req = 2'b10;
    wait_gnt(20);
    req = 2'b00; we = 2'b00;
    repeat (3) @(negedge clk);

    // Reset during BUSY aborts without a grant; next tie goes to A
    addr_a = 32'h00000040; addr_b = 32'h00000080; wdata_a = 32'h0; wdata_b = 32'h0;
    ack_wait = 10;
    push_txn(1'b0, 32'h00000040, 32'h0, 0);
    req = 2'b01;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_gnt", {30'd0, gnt}, 32'd0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    ack_wait = 0; resp_key = 32'h0;
    push_txn(1'b0, 32'h00000040, 32'h0, 1);
    push_gnt(2'b01, 32'h00000040);
    req = 2'b11;
    wait_gnt(20);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // A drops req mid-BUSY, still completes; then B served
    addr_a = 32'h00000300; addr_b = 32'h00000500;
    resp_key = 32'h0F0F0F0F; ack_wait = 2;
    push_txn(1'b0, 32'h00000300, 32'h0, 3);
    push_gnt(2'b01, 32'h0F0F0C0F);
    push_txn(1'b0, 32'h00000500, 32'h0, 3);
    push_gnt(2'b10, 32'h0F0F0A0F);
    req = 2'b01;
    @(negedge clk);
    req = 2'b10;
    wait_gnt(20);
    wait_gnt(20);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Stray mem_ack while IDLE is ignored
    resp_key = 32'hFFFFFFFF;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_rdata", rdata, 32'h0F0F0A0F);
    check("stray_gnt", {30'd0, gnt}, 32'd0);
    check("stray_mem_req", {31'd0, mem_req}, 32'd0);

    repeat (3) @(negedge clk);
    check("txn_queue_empty", exp_txn.size(), 32'd0);
    check("gnt_queue_empty", exp_gnt.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
